// File: rtl/stack_rpn_master_pkg.sv
// Shared types and constants for the RPN command master and its stack.
package stack_pkg;

    localparam int DATA_W = 4;
    localparam int IDX_W  = 3;
    localparam int DEPTH  = 5;

    localparam logic [1:0] CMD_NOP  = 2'd0;
    localparam logic [1:0] CMD_PUSH = 2'd1;
    localparam logic [1:0] CMD_POP  = 2'd2;
    localparam logic [1:0] CMD_GET  = 2'd3;

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_PEEK = 2'd2;
    localparam logic [1:0] OP_DUP  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PUSH_IN,
        ST_POP_B,
        ST_POP_A,
        ST_CAP_A,
        ST_PUSH_R,
        ST_GET0,
        ST_CAP_G,
        ST_REPORT,
        ST_ERROR
    } rpn_state_t;

endpackage

// File: rtl/stack_rpn_master_if.sv
// Token input, result output and stack command bus of the RPN master.
interface stack_rpn_master_if;
    import stack_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_kind;
    logic [DATA_W-1:0] in_data;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              err;
    logic [IDX_W-1:0]  depth_o;
    logic [1:0]        s_command;
    logic [IDX_W-1:0]  s_index;
    logic [DATA_W-1:0] s_i_data;
    logic [DATA_W-1:0] s_o_data;

    modport master (
        input  in_valid, in_kind, in_data, s_o_data,
        output in_ready, res_valid, res_data, err, depth_o,
               s_command, s_index, s_i_data
    );

    modport slave (
        output in_valid, in_kind, in_data, s_o_data,
        input  in_ready, res_valid, res_data, err, depth_o,
               s_command, s_index, s_i_data
    );

endinterface

// File: rtl/stack_rpn_master.sv
// RPN token master: turns operands/operators into stack PUSH/POP/GET sequences.
module stack_rpn_master
    import stack_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    stack_rpn_master_if.master bus
);

    rpn_state_t        state, next_state;
    logic [1:0]        cmd_q, cmd_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] idata_q, idata_d;
    logic              rv_q, rv_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  depth_q, depth_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] hold_q;
    logic              sub_q, dup_q;
    logic              accept, tok_err;
    logic [1:0]        op;
    logic [DATA_W-1:0] result;

    assign op     = bus.in_data[1:0];
    assign accept = bus.in_valid && (state == ST_IDLE);
    // During CAP_A the stack output holds a (the deeper element); b was captured earlier.
    assign result = sub_q ? (bus.s_o_data - hold_q) : (bus.s_o_data + hold_q);

    // Decide whether the offered token is legal for the current occupancy.
    always_comb begin
        tok_err = 1'b0;
        if (!bus.in_kind) begin
            tok_err = (depth_q == IDX_W'(DEPTH));
        end else begin
            case (op)
                OP_ADD, OP_SUB: tok_err = (depth_q < IDX_W'(2));
                OP_PEEK:        tok_err = (depth_q == '0);
                default:        tok_err = (depth_q == '0) || (depth_q == IDX_W'(DEPTH));
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Sequence each token through its fixed command schedule.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (tok_err)               next_state = ST_ERROR;
                    else if (!bus.in_kind)     next_state = ST_PUSH_IN;
                    else if (op == OP_ADD || op == OP_SUB) next_state = ST_POP_B;
                    else                       next_state = ST_GET0;
                end
            end
            ST_PUSH_IN: next_state = ST_IDLE;
            ST_POP_B:   next_state = ST_POP_A;
            ST_POP_A:   next_state = ST_CAP_A;
            ST_CAP_A:   next_state = ST_PUSH_R;
            ST_PUSH_R:  next_state = ST_IDLE;
            ST_GET0:    next_state = ST_CAP_G;
            ST_CAP_G:   next_state = ST_REPORT;
            ST_REPORT:  next_state = ST_IDLE;
            ST_ERROR:   next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, chosen by the state being entered.
    always_comb begin
        cmd_d   = CMD_NOP;
        idx_d   = '0;
        idata_d = idata_q;
        rv_d    = 1'b0;
        rd_d    = rd_q;
        err_d   = 1'b0;
        depth_d = depth_q;
        ready_d = (next_state == ST_IDLE);
        case (next_state)
            ST_PUSH_IN: begin
                cmd_d   = CMD_PUSH;
                idata_d = bus.in_data;
                depth_d = depth_q + IDX_W'(1);
            end
            ST_POP_B, ST_POP_A: begin
                cmd_d   = CMD_POP;
                depth_d = depth_q - IDX_W'(1);
            end
            ST_PUSH_R: begin
                cmd_d   = CMD_PUSH;
                idata_d = result;
                rv_d    = 1'b1;
                rd_d    = result;
                depth_d = depth_q + IDX_W'(1);
            end
            ST_GET0: begin
                cmd_d = CMD_GET;
                idx_d = '0;
            end
            ST_REPORT: begin
                rv_d = 1'b1;
                rd_d = bus.s_o_data;
                if (dup_q) begin
                    cmd_d   = CMD_PUSH;
                    idata_d = bus.s_o_data;
                    depth_d = depth_q + IDX_W'(1);
                end
            end
            ST_ERROR: err_d = 1'b1;
            default: ;
        endcase
    end

    // Output registers; ready resets high so it rises as soon as reset drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_q   <= CMD_NOP;
            idx_q   <= '0;
            idata_q <= '0;
            rv_q    <= 1'b0;
            rd_q    <= '0;
            err_q   <= 1'b0;
            depth_q <= '0;
            ready_q <= 1'b1;
        end else begin
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            idata_q <= idata_d;
            rv_q    <= rv_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            depth_q <= depth_d;
            ready_q <= ready_d;
        end
    end

    // Operator flavour latched at acceptance, operand b latched as the first pop lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            sub_q  <= 1'b0;
            dup_q  <= 1'b0;
        end else begin
            if (accept) begin
                sub_q <= (op == OP_SUB);
                dup_q <= (op == OP_DUP);
            end
            if (state == ST_POP_A) hold_q <= bus.s_o_data;
        end
    end

    assign bus.in_ready  = ready_q & ~rst;
    assign bus.res_valid = rv_q;
    assign bus.res_data  = rd_q;
    assign bus.err       = err_q;
    assign bus.depth_o   = depth_q;
    assign bus.s_command = cmd_q;
    assign bus.s_index   = idx_q;
    assign bus.s_i_data  = idata_q;

endmodule

// File: tb/tb_stack_rpn_master.sv
// Bench for stack_rpn_master: behavioural stack beside the DUT, queue-based RPN model.
module tb_stack_rpn_master;
    import stack_pkg::*;

    typedef struct packed {
        logic [11:0] cmds;
        logic [2:0]  rv_cnt;
        logic [2:0]  rv_at;
        logic [3:0]  rd;
        logic [2:0]  err_cnt;
        logic [2:0]  err_at;
        logic [3:0]  push_data;
        logic [2:0]  idx_or;
        logic [2:0]  depth;
        logic        ready;
    } trace_t;

    localparam logic [4:0] T_ADD  = {3'b100, OP_ADD};
    localparam logic [4:0] T_SUB  = {3'b100, OP_SUB};
    localparam logic [4:0] T_PEEK = {3'b100, OP_PEEK};
    localparam logic [4:0] T_DUP  = {3'b100, OP_DUP};

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   model_stk[$];

    stack_rpn_master_if bus();

    stack_rpn_master dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stack: PUSH/POP/GET executed at the clock edge, index 0 = top.
    logic [3:0] smem [DEPTH];
    int         sp;
    logic [3:0] stk_o;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sp    <= 0;
            stk_o <= '0;
        end else begin
            case (bus.s_command)
                CMD_PUSH: if (sp < DEPTH) begin
                    smem[sp] <= bus.s_i_data;
                    sp       <= sp + 1;
                end
                CMD_POP: if (sp > 0) begin
                    stk_o <= smem[sp-1];
                    sp    <= sp - 1;
                end
                CMD_GET: if (sp > int'(bus.s_index)) stk_o <= smem[sp-1-int'(bus.s_index)];
                default: ;
            endcase
        end
    end
    assign bus.s_o_data = stk_o;

    // Expected trace of one token, evaluated as plain RPN on a queue.
    function automatic trace_t predict(input logic kind, input logic [3:0] data);
        trace_t     e;
        logic [3:0] a, b, r;
        int         sz;
        bit         bad;
        e   = '0;
        sz  = model_stk.size();
        bad = 1'b0;
        e.ready = 1'b1;
        if (!kind) begin
            if (sz == DEPTH) bad = 1'b1;
            else begin
                model_stk.push_back(int'(data));
                e.cmds[1:0] = CMD_PUSH;
                e.push_data = data;
            end
        end else begin
            case (data[1:0])
                OP_ADD, OP_SUB: begin
                    if (sz < 2) bad = 1'b1;
                    else begin
                        b = 4'(model_stk.pop_back());
                        a = 4'(model_stk.pop_back());
                        r = (data[1:0] == OP_ADD) ? 4'((int'(a) + int'(b)) % 16)
                                                  : 4'((int'(a) - int'(b) + 16) % 16);
                        model_stk.push_back(int'(r));
                        e.cmds   = {2'd0, 2'd0, CMD_PUSH, CMD_NOP, CMD_POP, CMD_POP};
                        e.rv_cnt = 3'd1;
                        e.rv_at  = 3'd4;
                        e.rd     = r;
                        e.push_data = r;
                    end
                end
                OP_PEEK: begin
                    if (sz == 0) bad = 1'b1;
                    else begin
                        e.cmds[1:0] = CMD_GET;
                        e.rv_cnt = 3'd1;
                        e.rv_at  = 3'd3;
                        e.rd     = 4'(model_stk[sz-1]);
                    end
                end
                default: begin
                    if (sz == 0 || sz == DEPTH) bad = 1'b1;
                    else begin
                        e.cmds   = {2'd0, 2'd0, 2'd0, CMD_PUSH, CMD_NOP, CMD_GET};
                        e.rv_cnt = 3'd1;
                        e.rv_at  = 3'd3;
                        e.rd     = 4'(model_stk[sz-1]);
                        e.push_data = e.rd;
                        model_stk.push_back(model_stk[sz-1]);
                    end
                end
            endcase
        end
        if (bad) begin
            e.err_cnt = 3'd1;
            e.err_at  = 3'd1;
        end
        e.depth = 3'(model_stk.size());
        return e;
    endfunction

    // Offer one token, then record cycles c1..c6 after acceptance.
    task automatic issue(input logic kind, input logic [3:0] data, output trace_t o, output bit to);
        int waited;
        o  = '0;
        to = 1'b0;
        waited = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_data  = data;
        while (!bus.in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            to = 1'b1;
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_kind  = 1'($urandom);
        bus.in_data  = 4'($urandom);
        for (int k = 1; k <= 6; k++) begin
            o.cmds[2*(k-1) +: 2] = bus.s_command;
            if (bus.s_command == CMD_PUSH) o.push_data = bus.s_i_data;
            o.idx_or = o.idx_or | bus.s_index;
            if (bus.res_valid) begin
                o.rv_cnt = o.rv_cnt + 3'd1;
                o.rv_at  = 3'(k);
                o.rd     = bus.res_data;
            end
            if (bus.err) begin
                o.err_cnt = o.err_cnt + 3'd1;
                o.err_at  = 3'(k);
            end
            if (k == 6) begin
                o.depth = bus.depth_o;
                o.ready = bus.in_ready;
            end else begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_stk.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_kind  = 1'b0;
        bus.in_data  = '0;
        #13;
        checks++;
        if ({bus.s_command, bus.s_index, bus.s_i_data, bus.res_valid, bus.res_data,
             bus.err, bus.depth_o, bus.in_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values got cmd=%0d idx=%0d idata=%0d rv=%0b rd=%0d err=%0b depth=%0d ready=%0b want all 0",
                     bus.s_command, bus.s_index, bus.s_i_data, bus.res_valid, bus.res_data,
                     bus.err, bus.depth_o, bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got %0b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        logic [4:0] seq [3] = '{5'h03, 5'h09, T_ADD};
        trace_t o, e;
        bit to;
        for (int i = 0; i < 3; i++) begin
            e = predict(seq[i][4], seq[i][3:0]);
            issue(seq[i][4], seq[i][3:0], o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("[TB] FAIL add_tok%0d got=%h want=%h timeout=%0b", i, o, e, to);
            end
        end
        checks++;
        if (o.rd !== 4'd12 || o.rv_at !== 3'd4 || o.depth !== 3'd1) begin
            errors++;
            $display("[TB] FAIL add_result got rd=%0d at c%0d depth=%0d want 12 at c4 depth 1", o.rd, o.rv_at, o.depth);
        end
    endtask

    task automatic test_sub_peek();
        logic [4:0] seq [4] = '{5'h02, 5'h05, T_SUB, T_PEEK};
        trace_t o, e;
        bit to;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e = predict(seq[i][4], seq[i][3:0]);
            issue(seq[i][4], seq[i][3:0], o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("[TB] FAIL sub_peek_tok%0d got=%h want=%h timeout=%0b", i, o, e, to);
            end
        end
        checks++;
        if (o.rd !== 4'd13 || o.depth !== 3'd1 || o.cmds[1:0] !== CMD_GET) begin
            errors++;
            $display("[TB] FAIL sub_peek_result got rd=%0d depth=%0d c1cmd=%0d want 13 1 3", o.rd, o.depth, o.cmds[1:0]);
        end
    endtask

    task automatic test_empty_errors();
        logic [4:0] seq [2] = '{T_ADD, T_PEEK};
        trace_t o, e;
        bit to;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            e = predict(seq[i][4], seq[i][3:0]);
            issue(seq[i][4], seq[i][3:0], o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("[TB] FAIL empty_tok%0d got=%h want=%h timeout=%0b", i, o, e, to);
            end
            checks++;
            if (o.err_at !== 3'd1 || o.cmds !== '0 || o.depth !== 3'd0) begin
                errors++;
                $display("[TB] FAIL empty_err%0d got err_at=%0d cmds=%h depth=%0d want 1 000 0", i, o.err_at, o.cmds, o.depth);
            end
        end
    endtask

    task automatic test_overflow();
        logic [4:0] seq [8] = '{5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, T_DUP, T_PEEK};
        trace_t o, e;
        bit to;
        for (int i = 0; i < 8; i++) begin
            e = predict(seq[i][4], seq[i][3:0]);
            issue(seq[i][4], seq[i][3:0], o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("[TB] FAIL overflow_tok%0d got=%h want=%h timeout=%0b", i, o, e, to);
            end
        end
        checks++;
        if (o.rd !== 4'd5 || o.depth !== 3'd5) begin
            errors++;
            $display("[TB] FAIL overflow_peek got rd=%0d depth=%0d want 5 5", o.rd, o.depth);
        end
    endtask

    task automatic test_dup_add();
        logic [4:0] seq [3] = '{5'h07, T_DUP, T_ADD};
        trace_t o, e;
        bit to;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e = predict(seq[i][4], seq[i][3:0]);
            issue(seq[i][4], seq[i][3:0], o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("[TB] FAIL dup_add_tok%0d got=%h want=%h timeout=%0b", i, o, e, to);
            end
        end
        checks++;
        if (o.rd !== 4'd14 || o.depth !== 3'd1) begin
            errors++;
            $display("[TB] FAIL dup_add_result got rd=%0d depth=%0d want 14 1", o.rd, o.depth);
        end
    endtask

    task automatic test_reset_mid();
        trace_t o, e;
        bit to;
        do_reset();
        e = predict(1'b0, 4'd3); issue(1'b0, 4'd3, o, to);
        e = predict(1'b0, 4'd9); issue(1'b0, 4'd9, o, to);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_kind  = 1'b1;
        bus.in_data  = {2'b00, OP_ADD};
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.s_command !== CMD_POP) begin
            errors++;
            $display("[TB] FAIL reset_mid_c1 got cmd=%0d want %0d", bus.s_command, CMD_POP);
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.s_command, bus.s_index, bus.s_i_data, bus.res_valid, bus.res_data,
             bus.err, bus.depth_o, bus.in_ready} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_values got cmd=%0d depth=%0d ready=%0b rv=%0b err=%0b want all 0",
                     bus.s_command, bus.depth_o, bus.in_ready, bus.res_valid, bus.err);
        end
        @(negedge clk);
        rst = 1'b0;
        model_stk.delete();
        e = predict(T_PEEK[4], T_PEEK[3:0]);
        issue(T_PEEK[4], T_PEEK[3:0], o, to);
        checks++;
        if (to || o !== e || o.err_at !== 3'd1) begin
            errors++;
            $display("[TB] FAIL reset_mid_peek got=%h want=%h timeout=%0b", o, e, to);
        end
    endtask

    task automatic test_random();
        trace_t     o, e;
        bit         to;
        logic       kind;
        logic [3:0] data;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            kind = ($urandom_range(0, 9) >= 5);
            data = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            e = predict(kind, data);
            issue(kind, data, o, to);
            checks++;
            if (to || o !== e) begin
                errors++;
                $display("[TB] FAIL random_tok%0d kind=%0b data=%0d got=%h want=%h timeout=%0b", i, kind, data, o, e, to);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add();
        test_sub_peek();
        test_empty_errors();
        test_overflow();
        test_dup_add();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_rpn_master.md
Name: stack_rpn_master

Overview:
- Command-side initiator for the 4-bit stack block, which has a COMMAND/INDEX/I_DATA/O_DATA port.
- Accepts a token stream under a valid/ready handshake. Tokens are operands or operators.
- Turns each token into a sequence of PUSH/POP/GET commands to the stack, performs 4-bit arithmetic, and reports results.
- Sits between a token source and one stack instance. Both blocks share CLK and RESET.

Parameters:
- DATA_W, 4, width of stack data and operands.
- IDX_W, 3, width of the stack INDEX port.
- DEPTH, 5, stack capacity; used for overflow and underflow checks.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset. The same net also resets the stack.
- IN_VALID  in  1  token present.
- IN_READY  out  1  master can accept a token.
- IN_KIND  in  1  0 = operand, 1 = operator.
- IN_DATA  in  DATA_W  operand value, or operator code in bits [1:0].
- RES_VALID  out  1  one-cycle pulse; RES_DATA is valid.
- RES_DATA  out  DATA_W  result value.
- ERR  out  1  one-cycle pulse; the token was rejected.
- DEPTH_O  out  IDX_W  current tracked stack occupancy.
- S_COMMAND  out  2  to stack COMMAND: 0 NOP, 1 PUSH, 2 POP, 3 GET.
- S_INDEX  out  IDX_W  to stack INDEX.
- S_I_DATA  out  DATA_W  to stack I_DATA.
- S_O_DATA  in  DATA_W  from stack O_DATA. It is updated at the edge that executes POP or GET.

Behaviour:
- Reset values:
  - State IDLE.
  - IN_READY = 1 once reset deasserts; 0 while RESET is high.
  - RES_VALID = 0, RES_DATA = 0, ERR = 0, DEPTH_O = 0.
  - S_COMMAND = NOP, S_INDEX = 0, S_I_DATA = 0.
- All outputs are registered.
- Handshake:
  - A token is accepted at an edge where IN_VALID and IN_READY are both 1.
  - IN_READY = 1 only in IDLE.
  - IN_DATA and IN_KIND are captured at acceptance. The source may change them afterwards.
- Cycle numbering: c0 = acceptance edge; cN = the Nth cycle after it.
- S_COMMAND is NOP in every cycle not listed below. Each command lasts exactly one cycle.
- Operator codes: 0 ADD, 1 SUB, 2 PEEK, 3 DUP.
- Operand (state PUSH_IN):
  - c1: PUSH with S_I_DATA = value; DEPTH_O increments.
  - c2: back in IDLE.
- ADD / SUB (states POP_B, POP_A, CAP_A, PUSH_R):
  - c1: POP.
  - c2: POP; capture b from S_O_DATA at the end of c2.
  - c3: capture a at the end of c3.
  - c4: PUSH result; RES_VALID = 1 with RES_DATA = result.
  - c5: IDLE.
  - Result is a+b or a−b modulo 2^DATA_W; the carry or borrow is dropped.
  - a is the deeper element, b the top.
  - Net DEPTH_O change is −1.
- PEEK (states GET0, CAP_G, REPORT):
  - c1: GET with S_INDEX = 0.
  - c2: capture top.
  - c3: RES_VALID pulse with the top value.
  - DEPTH_O unchanged.
- DUP: same as PEEK, except c3 also issues PUSH of the captured value. DEPTH_O +1.
- Error checks, evaluated at acceptance:
  - Operand with DEPTH_O == DEPTH.
  - ADD/SUB with DEPTH_O < 2.
  - PEEK with DEPTH_O == 0.
  - DUP with DEPTH_O == 0 or == DEPTH.
- Error response: token consumed; c1 ERR = 1; no stack command issued; DEPTH_O unchanged; c2 IDLE.
- RES_VALID and ERR never assert in the same cycle.
- Reset mid-sequence: state returns to IDLE immediately and all outputs go to their reset values. A partially applied sequence is abandoned; the stack is cleared by the same RESET.
- IN_VALID while busy is ignored; the source must hold it until accepted.

Decomposition:
- Package stack_pkg:
  - Command constants CMD_NOP, CMD_PUSH, CMD_POP, CMD_GET.
  - Operator constants OP_ADD, OP_SUB, OP_PEEK, OP_DUP.
  - State enum type rpn_state_t.
  - DATA_W and IDX_W defaults.
- No sub-module: the arithmetic is one adder and subtractor inside the FSM. The bench instantiates the real stack beside the master.

Test Plan:
- Push 3, push 9, ADD -> S_COMMAND shows PUSH, PUSH, POP, POP, PUSH(12); RES_VALID pulses with RES_DATA = 12 at c4; DEPTH_O = 1.
- Push 2, push 5, SUB -> RES_DATA = 13 (2−5 mod 16); a following PEEK returns 13 with GET index 0 and DEPTH_O stays 1.
- ADD on an empty stack, then PEEK on an empty stack -> ERR pulse at c1 each time; S_COMMAND stays NOP; DEPTH_O = 0.
- Push 1..5, then push 6 -> ERR on the sixth token with no PUSH issued; DUP also gives ERR; PEEK returns 5.
- Push 7, DUP, ADD -> DUP reports 7 and pushes it; ADD reports 14; DEPTH_O = 1.
- Assert RESET during c2 of an ADD -> outputs return to reset values in the same cycle; after release a PEEK gives ERR (depth 0).
